cdc_hs_receiver: RTL

Parametrised receive side of a four-phase req/ack clock-domain-crossing handshake, running in the clk_b domain. Synchronises the incoming request through a configurable flop chain, captures the sender's bus into a small show-ahead FIFO, and returns data_ack. The FIFO feeds a valid/ready stream to downstream logic. Unlike the fixed 4-bit receiver, data_ack is withheld while the FIFO is full, so the sender sees backpressure and nothing is dropped.

---
 rtl/cdc_hs_pkg.sv | 18 +
 rtl/cdc_sync_bit.sv | 27 ++
 rtl/cdc_hs_receiver.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cdc_hs_pkg.sv
// Shared types and default constants for the req/ack clock-domain-crossing
// handshake blocks (receiver now, sender later).
//   rx_state_t       : receiver FSM states
//   DATA_W_DEF       : default crossing bus width
//   SYNC_STAGES_DEF  : default synchroniser depth
//   FIFO_DEPTH_DEF   : default receive FIFO depth
package cdc_hs_pkg;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_t;

  localparam int DATA_W_DEF      = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FIFO_DEPTH_DEF  = 2;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchroniser, all flops reset to 0.
//   clk    : destination-domain clock
//   rst_n  : asynchronous active-low reset
//   d      : asynchronous input bit
//   q      : synchronised output (last flop of the chain)
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_hs_receiver.sv
// Receive side of a four-phase req/ack CDC handshake in the clk_b domain.
// The request is synchronised, the sender bus is captured into a small
// show-ahead FIFO and data_ack is returned. data_ack is withheld while the
// FIFO is full so the sender is back-pressured instead of losing words.
//   clk_b      : receive-domain clock
//   rst_n      : asynchronous active-low reset
//   data_req   : request from the sender domain (asynchronous)
//   data       : sender bus, stable while the request is outstanding
//   data_ack   : registered acknowledge back to the sender
//   out_data   : FIFO head (show-ahead)
//   out_valid  : FIFO non-empty
//   out_ready  : downstream accept; pop on out_valid & out_ready
//   level      : FIFO occupancy, 0..FIFO_DEPTH
//   abort_err  : sticky, set when a held request is withdrawn uncaptured
module cdc_hs_receiver
  import cdc_hs_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                          clk_b,
  input  logic                          rst_n,
  input  logic                          data_req,
  input  logic [DATA_W-1:0]             data,
  output logic                          data_ack,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          abort_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic              req_s;
  rx_state_t         state, state_nxt;
  logic              held_q, held_nxt;
  logic              abort_set;
  logic              push, pop, full, empty;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  cdc_sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk   (clk_b),
    .rst_n (rst_n),
    .d     (data_req),
    .q     (req_s)
  );

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  // full comes from registered pointers, so a pop this cycle only frees the
  // slot for the next edge.
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);
  assign pop   = !empty && out_ready;

  // held_q remembers that req_s was seen high while full; if req_s then
  // drops before any capture the sender has abandoned the word.
  always_comb begin
    state_nxt = state;
    held_nxt  = held_q;
    push      = 1'b0;
    abort_set = 1'b0;
    case (state)
      RX_IDLE: begin
        if (req_s) begin
          if (!full) begin
            push      = 1'b1;
            held_nxt  = 1'b0;
            state_nxt = RX_ACK;
          end else begin
            held_nxt  = 1'b1;
          end
        end else if (held_q) begin
          abort_set = 1'b1;
          held_nxt  = 1'b0;
        end
      end
      RX_ACK: begin
        if (!req_s) begin
          state_nxt = RX_IDLE;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      held_q    <= 1'b0;
      abort_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      held_q <= held_nxt;
      if (abort_set) begin
        abort_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Storage is cleared on reset so out_data reads 0 out of reset.
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '{default: '0};
    end else if (push) begin
      mem[wr_ptr[AW-1:0]] <= data;
    end
  end

  assign data_ack  = (state == RX_ACK);
  assign out_data  = mem[rd_ptr[AW-1:0]];
  assign out_valid = !empty;
  assign level     = wr_ptr - rd_ptr;

endmodule
